signed_seq_divider: RTL

- Iterative signed divider; inverse of the 32x32→64 Booth multiplier datapath.
- Takes a 2W-bit dividend and a W-bit divisor; returns a W-bit quotient and W-bit remainder.
- Any 64-bit product from the multiplier, divided by one of its factors, returns the other factor with zero remainder.
- Sits beside the multiplier in the arithmetic unit, behind the same register-load/enable style of control.

---
 rtl/mult_div_pkg.sv | 15 +
 rtl/twos_negate.sv | 12 +
 rtl/signed_seq_divider.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/mult_div_pkg.sv
// Definitions shared by the Booth multiplier and the signed sequential divider.
package mult_div_pkg;

    localparam int WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        ITER,
        FIX
    } state_t;

    localparam logic [WIDTH-1:0] DIV_ZERO_QUOT = '1;

endpackage

// File: rtl/twos_negate.sv
// Conditional two's-complement negate; purely combinational, zero latency, no flow control.
module twos_negate #(
    parameter int W = 32
) (
    input  logic [W-1:0] val_i,
    input  logic         neg_i,
    output logic [W-1:0] val_o
);

    assign val_o = neg_i ? (~val_i + W'(1)) : val_i;

endmodule

// File: rtl/signed_seq_divider.sv
// Restoring signed divider, 2W/W -> W quotient and remainder; done WIDTH+2 edges after start (2 on errors).
// A single operation is in flight; start is ignored while busy and operands are captured only on acceptance.
module signed_seq_divider
    import mult_div_pkg::*;
#(
    parameter int WIDTH = mult_div_pkg::WIDTH
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic                 start,
    input  logic [2*WIDTH-1:0]   Dividend,
    input  logic [WIDTH-1:0]     Divisor,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     Quotient,
    output logic [WIDTH-1:0]     Remainder,
    output logic                 divByZero,
    output logic                 overflow
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] MIN_MAG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   dvd_q, dvd_d;
    logic [WIDTH-1:0]     dvs_q, dvs_d;
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic [WIDTH-1:0]     low_q, low_d;
    logic [WIDTH-1:0]     dmag_q, dmag_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 dbz_q, dbz_d;
    logic                 ovf_q, ovf_d;
    logic [WIDTH-1:0]     quot_q, quot_d;
    logic [WIDTH-1:0]     remo_q, remo_d;
    logic                 dbz_o_q, dbz_o_d;
    logic                 ovf_o_q, ovf_o_d;
    logic                 done_q, done_d;

    logic [2*WIDTH-1:0]   dvd_abs;
    logic [WIDTH-1:0]     dvs_abs;
    logic [WIDTH-1:0]     quo_signed;
    logic [WIDTH-1:0]     rem_signed;
    logic [WIDTH:0]       shifted;
    logic [WIDTH:0]       diff;
    logic                 qbit;
    logic                 q_neg;
    logic                 rng_ovf;

    twos_negate #(.W(2*WIDTH)) u_abs_dvd (
        .val_i (dvd_q),
        .neg_i (dvd_q[2*WIDTH-1]),
        .val_o (dvd_abs)
    );

    twos_negate #(.W(WIDTH)) u_abs_dvs (
        .val_i (dvs_q),
        .neg_i (dvs_q[WIDTH-1]),
        .val_o (dvs_abs)
    );

    assign q_neg = dvd_q[2*WIDTH-1] ^ dvs_q[WIDTH-1];

    twos_negate #(.W(WIDTH)) u_sgn_quo (
        .val_i (low_q),
        .neg_i (q_neg),
        .val_o (quo_signed)
    );

    twos_negate #(.W(WIDTH)) u_sgn_rem (
        .val_i (rem_q),
        .neg_i (dvd_q[2*WIDTH-1]),
        .val_o (rem_signed)
    );

    // rem < |divisor| <= 2^(W-1), so the shifted value never reaches bit W and diff[W] is a true sign.
    assign shifted = {rem_q, low_q[WIDTH-1]};
    assign diff    = shifted - {1'b0, dmag_q};
    assign qbit    = ~diff[WIDTH];
    assign rng_ovf = q_neg ? (low_q > MIN_MAG) : low_q[WIDTH-1];

    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        low_d   = low_q;
        dmag_d  = dmag_q;
        cnt_d   = cnt_q;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;
        quot_d  = quot_q;
        remo_d  = remo_q;
        dbz_o_d = dbz_o_q;
        ovf_o_d = ovf_o_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    dvd_d   = Dividend;
                    dvs_d   = Divisor;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                dbz_d  = (dvs_q == '0);
                ovf_d  = (dvs_q != '0) && (dvd_abs[2*WIDTH-1:WIDTH] >= dvs_abs);
                rem_d  = dvd_abs[2*WIDTH-1:WIDTH];
                low_d  = dvd_abs[WIDTH-1:0];
                dmag_d = dvs_abs;
                cnt_d  = '0;
                state_d = (dbz_d || ovf_d) ? FIX : ITER;
            end
            ITER: begin
                rem_d = qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
                low_d = {low_q[WIDTH-2:0], qbit};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH-1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                done_d  = 1'b1;
                state_d = IDLE;
                if (dbz_q) begin
                    quot_d  = WIDTH'(DIV_ZERO_QUOT);
                    remo_d  = dvd_q[WIDTH-1:0];
                    dbz_o_d = 1'b1;
                    ovf_o_d = 1'b0;
                end else if (ovf_q || rng_ovf) begin
                    quot_d  = '0;
                    remo_d  = '0;
                    dbz_o_d = 1'b0;
                    ovf_o_d = 1'b1;
                end else begin
                    quot_d  = quo_signed;
                    remo_d  = rem_signed;
                    dbz_o_d = 1'b0;
                    ovf_o_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= IDLE;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            low_q   <= '0;
            dmag_q  <= '0;
            cnt_q   <= '0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
            quot_q  <= '0;
            remo_q  <= '0;
            dbz_o_q <= 1'b0;
            ovf_o_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            low_q   <= low_d;
            dmag_q  <= dmag_d;
            cnt_q   <= cnt_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
            quot_q  <= quot_d;
            remo_q  <= remo_d;
            dbz_o_q <= dbz_o_d;
            ovf_o_q <= ovf_o_d;
            done_q  <= done_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign Quotient  = quot_q;
    assign Remainder = remo_q;
    assign divByZero = dbz_o_q;
    assign overflow  = ovf_o_q;

endmodule
